// File: rtl/quiz_pkg.sv
// Shared state encoding, winner codes and a small helper for the quiz round controller.
package quiz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GUARD,
        ARMED,
        RESULT,
        GAME_OVER
    } state_e;

    // Bit 0 flags player 1, bit 1 flags player 2, so a tie is simply both bits.
    typedef enum logic [1:0] {
        W_NONE = 2'b00,
        W_P1   = 2'b01,
        W_P2   = 2'b10,
        W_TIE  = 2'b11
    } winner_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/quiz_round_controller_if.sv
// Bundle between quiz_mode / random_number and the round controller.
interface quiz_round_controller_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               trigger;
    logic               correct_status_p1;
    logic               correct_status_p2;
    logic               quiz_reset;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [1:0]         round_winner;
    logic               round_active;
    logic               game_over;
    logic [1:0]         game_winner;

    modport master (
        output trigger, correct_status_p1, correct_status_p2,
        input  quiz_reset, score_p1, score_p2, round_winner,
               round_active, game_over, game_winner
    );

    modport slave (
        input  trigger, correct_status_p1, correct_status_p2,
        output quiz_reset, score_p1, score_p2, round_winner,
               round_active, game_over, game_winner
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge (or any-toggle) pulse detector.
module sync_edge #(
    parameter bit TOGGLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset preloads the live level everywhere, so a held input never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= din;
            sync_q <= din;
            prev_q <= din;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = TOGGLE ? (sync_q ^ prev_q) : (sync_q & ~prev_q);

endmodule

// File: rtl/quiz_round_controller.sv
// Round sequencer and scoreboard: clears quiz_mode flags per draw, picks round winners,
// keeps scores and declares the game winner.
module quiz_round_controller
    import quiz_pkg::*;
#(
    parameter int unsigned WIN_SCORE      = 5,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned CLR_CYCLES     = 8,
    parameter int unsigned GUARD_CYCLES   = 8,
    parameter int unsigned HOLD_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic                  basys3_clk,
    input  logic                  restart,
    quiz_round_controller_if.slave bus
);
    localparam int unsigned CNT_MAX = max_u(max_u(CLR_CYCLES, GUARD_CYCLES),
                                            max_u(HOLD_CYCLES, TIMEOUT_CYCLES));
    localparam int CNT_W = $clog2(64'(CNT_MAX) + 64'd1);

    localparam logic [SCORE_W-1:0] WIN          = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   CLR_LAST     = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic p1_rise, p2_rise, trig_toggle;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    winner_e            round_winner_q, round_winner_d;
    winner_e            game_winner_q, game_winner_d;
    logic               quiz_reset_q, quiz_reset_d;
    logic               round_active_q, round_active_d;
    logic               game_over_q, game_over_d;

    sync_edge #(.TOGGLE(1'b0)) u_sync_p1 (
        .clk(basys3_clk), .rst(restart), .din(bus.correct_status_p1), .pulse(p1_rise)
    );
    sync_edge #(.TOGGLE(1'b0)) u_sync_p2 (
        .clk(basys3_clk), .rst(restart), .din(bus.correct_status_p2), .pulse(p2_rise)
    );
    sync_edge #(.TOGGLE(1'b1)) u_sync_trig (
        .clk(basys3_clk), .rst(restart), .din(bus.trigger), .pulse(trig_toggle)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        score_p1_d     = score_p1_q;
        score_p2_d     = score_p2_q;
        round_winner_d = round_winner_q;
        game_winner_d  = game_winner_q;

        case (state_q)
            IDLE:   if (trig_toggle) state_d = CLEAR;
            CLEAR:  if (cnt_q == CLR_LAST) state_d = GUARD;
            GUARD:  if (cnt_q == GUARD_LAST) state_d = ARMED;
            ARMED: begin
                if (trig_toggle) begin
                    state_d = CLEAR;
                end else if (p1_rise || p2_rise) begin
                    round_winner_d = winner_e'({p2_rise, p1_rise});
                    if (p1_rise && score_p1_q < WIN) score_p1_d = score_p1_q + 1'b1;
                    if (p2_rise && score_p2_q < WIN) score_p2_d = score_p2_q + 1'b1;
                    state_d = RESULT;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_LAST) begin
                    round_winner_d = W_NONE;
                    state_d        = RESULT;
                end
            end
            RESULT: begin
                if (cnt_q == HOLD_LAST) begin
                    if (score_p1_q == WIN || score_p2_q == WIN) begin
                        game_winner_d = winner_e'({score_p2_q == WIN, score_p1_q == WIN});
                        state_d       = GAME_OVER;
                    end else begin
                        round_winner_d = W_NONE;
                        state_d        = IDLE;
                    end
                end
            end
            GAME_OVER: state_d = GAME_OVER;
            default:   state_d = IDLE;
        endcase

        // One shared timer: restarts on every state change, idles where nothing is timed.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {CLEAR, GUARD, ARMED, RESULT}) begin
            cnt_d = cnt_q + 1'b1;
        end

        quiz_reset_d   = (state_d == CLEAR);
        round_active_d = (state_d == ARMED);
        game_over_d    = (state_d == GAME_OVER);
    end

    always_ff @(posedge basys3_clk) begin
        if (restart) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            score_p1_q     <= '0;
            score_p2_q     <= '0;
            round_winner_q <= W_NONE;
            game_winner_q  <= W_NONE;
            quiz_reset_q   <= 1'b1;
            round_active_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            round_winner_q <= round_winner_d;
            game_winner_q  <= game_winner_d;
            quiz_reset_q   <= quiz_reset_d;
            round_active_q <= round_active_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.quiz_reset   = quiz_reset_q;
    assign bus.score_p1     = score_p1_q;
    assign bus.score_p2     = score_p2_q;
    assign bus.round_winner = round_winner_q;
    assign bus.round_active = round_active_q;
    assign bus.game_over    = game_over_q;
    assign bus.game_winner  = game_winner_q;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Self-checking bench for quiz_round_controller: directed scenarios plus random rounds
// scored by a round-level model of the game rules.
module tb_quiz_round_controller;

    localparam int WIN_SCORE = 3;
    localparam int SCORE_W   = 4;
    localparam int CLR       = 4;
    localparam int GUARD     = 4;
    localparam int HOLD      = 10;
    localparam int TIMEOUT   = 50;

    localparam int K_P1      = 0;
    localparam int K_P2      = 1;
    localparam int K_TIE     = 2;
    localparam int K_TIMEOUT = 3;

    logic basys3_clk = 1'b0;
    logic restart;

    quiz_round_controller_if #(.SCORE_W(SCORE_W)) bus ();

    quiz_round_controller #(
        .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W), .CLR_CYCLES(CLR),
        .GUARD_CYCLES(GUARD), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .basys3_clk(basys3_clk),
        .restart(restart),
        .bus(bus.slave)
    );

    always #5 basys3_clk = ~basys3_clk;

    int checks   = 0;
    int failures = 0;
    int mdl_p1   = 0;
    int mdl_p2   = 0;

    // Round-level reference model of the game rules.
    function automatic logic [1:0] exp_winner(input int kind);
        case (kind)
            K_P1:    return 2'b01;
            K_P2:    return 2'b10;
            K_TIE:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_apply(input int kind);
        if ((kind == K_P1 || kind == K_TIE) && mdl_p1 < WIN_SCORE) mdl_p1++;
        if ((kind == K_P2 || kind == K_TIE) && mdl_p2 < WIN_SCORE) mdl_p2++;
    endtask

    function automatic bit model_over();
        return (mdl_p1 == WIN_SCORE) || (mdl_p2 == WIN_SCORE);
    endfunction

    function automatic logic [1:0] model_game_winner();
        return {mdl_p2 == WIN_SCORE, mdl_p1 == WIN_SCORE};
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge basys3_clk);
            #1;
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc(2);
        restart = 1'b0;
        cyc(1);
        mdl_p1 = 0;
        mdl_p2 = 0;
    endtask

    task automatic wait_arm(output int qr_len, output int guard_len, output bit ok);
        int n;
        n = 0;
        qr_len = 0;
        guard_len = 0;
        while (bus.quiz_reset !== 1'b1 && n < 10) begin cyc(); n++; end
        while (bus.quiz_reset === 1'b1 && qr_len < 3 * CLR) begin cyc(); qr_len++; end
        while (bus.round_active !== 1'b1 && guard_len < 3 * GUARD) begin cyc(); guard_len++; end
        ok = (bus.round_active === 1'b1);
    endtask

    task automatic start_round(output int qr_len, output int guard_len, output bit ok);
        bus.trigger = ~bus.trigger;
        wait_arm(qr_len, guard_len, ok);
    endtask

    // Drives one round's outcome from ARMED and samples the RESULT window.
    task automatic finish_round(input int kind, input int delay, output int active_len,
                                output int lat, output logic [1:0] w_first,
                                output logic [1:0] w_last, output logic [1:0] w_after,
                                output logic over_after, output bit ok);
        lat = 0;
        active_len = 0;
        if (kind != K_TIMEOUT) begin
            cyc(delay);
            active_len = delay;
            bus.correct_status_p1 = (kind == K_P1 || kind == K_TIE);
            bus.correct_status_p2 = (kind == K_P2 || kind == K_TIE);
        end
        while (bus.round_active === 1'b1 && lat < TIMEOUT + 10) begin cyc(); lat++; end
        active_len += lat;
        ok = (bus.round_active === 1'b0);
        bus.correct_status_p1 = 1'b0;
        bus.correct_status_p2 = 1'b0;
        w_first = bus.round_winner;
        cyc(HOLD - 1);
        w_last = bus.round_winner;
        cyc(1);
        w_after = bus.round_winner;
        over_after = bus.game_over;
    endtask

    task automatic test_reset();
        restart = 1'b1;
        cyc(2);
        checks++; if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin
            failures++; $display("FAIL reset_scores: got %0d/%0d want 0/0", bus.score_p1, bus.score_p2); end
        checks++; if (bus.quiz_reset !== 1'b1) begin
            failures++; $display("FAIL reset_quiz_reset: got %b want 1", bus.quiz_reset); end
        checks++; if (bus.round_active !== 1'b0 || bus.game_over !== 1'b0 ||
                      bus.round_winner !== 2'b00 || bus.game_winner !== 2'b00) begin
            failures++; $display("FAIL reset_flags: active=%b over=%b rw=%b gw=%b want 0 0 00 00",
                                 bus.round_active, bus.game_over, bus.round_winner, bus.game_winner); end
        restart = 1'b0;
        cyc(1);
        checks++; if (bus.quiz_reset !== 1'b0) begin
            failures++; $display("FAIL idle_quiz_reset: got %b want 0", bus.quiz_reset); end
        mdl_p1 = 0;
        mdl_p2 = 0;
    endtask

    task automatic test_p1_round();
        int qr, gd, act, lat;
        logic [1:0] wf, wl, wa;
        logic ov;
        bit ok;
        start_round(qr, gd, ok);
        checks++; if (qr != CLR) begin
            failures++; $display("FAIL clear_len: got %0d want %0d", qr, CLR); end
        checks++; if (gd != GUARD || !ok) begin
            failures++; $display("FAIL guard_len: got %0d armed=%b want %0d armed=1", gd, ok, GUARD); end
        finish_round(K_P1, 0, act, lat, wf, wl, wa, ov, ok);
        model_apply(K_P1);
        checks++; if (!ok || lat < 3 || lat > 4) begin
            failures++; $display("FAIL p1_latency: got %0d want 3..4", lat); end
        checks++; if (wf !== 2'b01 || wl !== 2'b01) begin
            failures++; $display("FAIL p1_winner_hold: got %b..%b want 01..01", wf, wl); end
        checks++; if (wa !== 2'b00 || ov !== 1'b0) begin
            failures++; $display("FAIL p1_back_idle: rw=%b over=%b want 00 0", wa, ov); end
        checks++; if (bus.score_p1 !== 4'(mdl_p1) || bus.score_p2 !== 4'(mdl_p2)) begin
            failures++; $display("FAIL p1_scores: got %0d/%0d want %0d/%0d",
                                 bus.score_p1, bus.score_p2, mdl_p1, mdl_p2); end
    endtask

    task automatic test_tie();
        int qr, gd, act, lat;
        logic [1:0] wf, wl, wa;
        logic ov;
        bit ok;
        start_round(qr, gd, ok);
        finish_round(K_TIE, 5, act, lat, wf, wl, wa, ov, ok);
        model_apply(K_TIE);
        checks++; if (!ok || wf !== 2'b11) begin
            failures++; $display("FAIL tie_winner: got %b want 11", wf); end
        checks++; if (bus.score_p1 !== 4'(mdl_p1) || bus.score_p2 !== 4'(mdl_p2)) begin
            failures++; $display("FAIL tie_scores: got %0d/%0d want %0d/%0d",
                                 bus.score_p1, bus.score_p2, mdl_p1, mdl_p2); end
    endtask

    task automatic test_timeout_reroll();
        int qr, gd, act, lat;
        logic [1:0] wf, wl, wa;
        logic ov;
        bit ok;
        start_round(qr, gd, ok);
        finish_round(K_TIMEOUT, 0, act, lat, wf, wl, wa, ov, ok);
        checks++; if (!ok || act != TIMEOUT) begin
            failures++; $display("FAIL timeout_len: got %0d want %0d", act, TIMEOUT); end
        checks++; if (wf !== 2'b00 || bus.score_p1 !== 4'(mdl_p1) || bus.score_p2 !== 4'(mdl_p2)) begin
            failures++; $display("FAIL timeout_result: rw=%b scores %0d/%0d want 00 %0d/%0d",
                                 wf, bus.score_p1, bus.score_p2, mdl_p1, mdl_p2); end
        start_round(qr, gd, ok);
        cyc(5);
        bus.trigger = ~bus.trigger;
        wait_arm(qr, gd, ok);
        checks++; if (qr != CLR || !ok) begin
            failures++; $display("FAIL reroll_clear: got %0d armed=%b want %0d armed=1", qr, ok, CLR); end
        checks++; if (bus.score_p1 !== 4'(mdl_p1) || bus.score_p2 !== 4'(mdl_p2)) begin
            failures++; $display("FAIL reroll_scores: got %0d/%0d want %0d/%0d",
                                 bus.score_p1, bus.score_p2, mdl_p1, mdl_p2); end
        finish_round(K_TIMEOUT, 0, act, lat, wf, wl, wa, ov, ok);
    endtask

    task automatic test_game_over();
        int qr, gd, act, lat;
        logic [1:0] wf, wl, wa;
        logic ov;
        bit ok;
        while (!model_over()) begin
            start_round(qr, gd, ok);
            finish_round(K_P2, 2, act, lat, wf, wl, wa, ov, ok);
            model_apply(K_P2);
            checks++; if (ov !== model_over()) begin
                failures++; $display("FAIL p2_game_over: got %b want %b (p2=%0d)", ov, model_over(), mdl_p2); end
            if (ov !== model_over()) break;
        end
        checks++; if (bus.game_winner !== model_game_winner()) begin
            failures++; $display("FAIL game_winner: got %b want %b", bus.game_winner, model_game_winner()); end
        bus.trigger = ~bus.trigger;
        cyc(12);
        checks++; if (bus.game_over !== 1'b1 || bus.quiz_reset !== 1'b0 || bus.round_active !== 1'b0) begin
            failures++; $display("FAIL game_over_sticky: over=%b qr=%b active=%b want 1 0 0",
                                 bus.game_over, bus.quiz_reset, bus.round_active); end
        do_restart();
        checks++; if (bus.game_over !== 1'b0 || bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0) begin
            failures++; $display("FAIL restart_after_game: over=%b scores %0d/%0d want 0 0/0",
                                 bus.game_over, bus.score_p1, bus.score_p2); end
    endtask

    task automatic test_held_level_restart_in_result();
        int qr, gd, n;
        bit ok;
        bus.correct_status_p1 = 1'b1;
        cyc(3);
        start_round(qr, gd, ok);
        cyc(20);
        checks++; if (!ok || bus.round_active !== 1'b1 || bus.score_p1 !== 4'd0) begin
            failures++; $display("FAIL held_level: active=%b p1=%0d want 1 0", bus.round_active, bus.score_p1); end
        bus.correct_status_p2 = 1'b1;
        n = 0;
        while (bus.round_active === 1'b1 && n < 10) begin cyc(); n++; end
        checks++; if (bus.round_winner !== 2'b10 || bus.score_p2 !== 4'd1 || bus.score_p1 !== 4'd0) begin
            failures++; $display("FAIL held_p2_wins: rw=%b scores %0d/%0d want 10 0/1",
                                 bus.round_winner, bus.score_p1, bus.score_p2); end
        cyc(3);
        restart = 1'b1;
        cyc(1);
        checks++; if (bus.score_p1 !== 4'd0 || bus.score_p2 !== 4'd0 || bus.round_winner !== 2'b00) begin
            failures++; $display("FAIL restart_in_result: scores %0d/%0d rw=%b want 0/0 00",
                                 bus.score_p1, bus.score_p2, bus.round_winner); end
        restart = 1'b0;
        bus.correct_status_p1 = 1'b0;
        bus.correct_status_p2 = 1'b0;
        cyc(1);
        checks++; if (bus.quiz_reset !== 1'b0 || bus.round_active !== 1'b0) begin
            failures++; $display("FAIL restart_to_idle: qr=%b active=%b want 0 0", bus.quiz_reset, bus.round_active); end
        mdl_p1 = 0;
        mdl_p2 = 0;
    endtask

    task automatic test_random_rounds();
        int qr, gd, act, lat, kind, delay;
        logic [1:0] wf, wl, wa;
        logic ov;
        bit ok;
        for (int r = 0; r < 14; r++) begin
            kind  = int'($urandom_range(0, 3));
            delay = int'($urandom_range(0, 20));
            start_round(qr, gd, ok);
            checks++; if (!ok) begin
                failures++; $display("FAIL rnd_arm r%0d: round never armed", r); end
            finish_round(kind, delay, act, lat, wf, wl, wa, ov, ok);
            model_apply(kind);
            checks++; if (!ok || wf !== exp_winner(kind) || wl !== exp_winner(kind)) begin
                failures++; $display("FAIL rnd_winner r%0d kind %0d: got %b..%b want %b",
                                     r, kind, wf, wl, exp_winner(kind)); end
            checks++; if (bus.score_p1 !== 4'(mdl_p1) || bus.score_p2 !== 4'(mdl_p2)) begin
                failures++; $display("FAIL rnd_scores r%0d: got %0d/%0d want %0d/%0d",
                                     r, bus.score_p1, bus.score_p2, mdl_p1, mdl_p2); end
            checks++; if (ov !== model_over()) begin
                failures++; $display("FAIL rnd_game_over r%0d: got %b want %b", r, ov, model_over()); end
            if (model_over()) begin
                checks++; if (bus.game_winner !== model_game_winner()) begin
                    failures++; $display("FAIL rnd_game_winner r%0d: got %b want %b",
                                         r, bus.game_winner, model_game_winner()); end
                do_restart();
            end else begin
                checks++; if (wa !== 2'b00) begin
                    failures++; $display("FAIL rnd_winner_clear r%0d: got %b want 00", r, wa); end
            end
        end
    endtask

    initial begin
        restart               = 1'b1;
        bus.trigger           = 1'b0;
        bus.correct_status_p1 = 1'b0;
        bus.correct_status_p2 = 1'b0;
        test_reset();
        test_p1_round();
        test_tie();
        test_timeout_reroll();
        test_game_over();
        test_held_level_restart_in_result();
        test_random_rounds();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
